// File: rtl/vga_sprite_fetch.sv
// ---------------------------------------------------------------------------
// vga_sprite_fetch
//
// Pixel-fetch stage between the 800x600@60 timing generator and the display
// output. Pixels that fall inside a movable IMG_W x IMG_H window are mapped to
// addresses of a synchronous image ROM. The returned RGB565 data is muxed with
// a background colour. DE/HS/VS are delayed so they stay aligned with the data.
// The window can optionally bounce around the screen. Its position updates
// once per frame, on the rising edge of vertical sync.
//
// Ports:
//   CLK       in   pixel clock
//   RST_N     in   asynchronous active-low reset
//   H_CNT     in   current pixel x (valid while DE_IN=1)
//   V_CNT     in   current line y (valid while DE_IN=1)
//   DE_IN     in   active-video flag
//   HS_IN     in   horizontal sync
//   VS_IN     in   vertical sync, active-high
//   EN_MOVE   in   1 = bounce window each frame, 0 = hold position
//   ROM_Q     in   ROM read data, ROM_LAT cycles after ROM_ADDR
//   ROM_ADDR  out  ROM read address
//   DATA_OUT  out  RGB565 pixel
//   DE_OUT    out  DE_IN delayed by 2+ROM_LAT cycles
//   HSYNC     out  HS_IN delayed by 2+ROM_LAT cycles
//   VSYNC     out  VS_IN delayed by 2+ROM_LAT cycles
//   POS_X     out  current window left edge
//   POS_Y     out  current window top edge
// ---------------------------------------------------------------------------
module vga_sprite_fetch #(
  parameter int          H_ACT    = 800,
  parameter int          V_ACT    = 600,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          ADDR_W   = 16,
  parameter int          ROM_LAT  = 2,
  parameter int          STEP     = 1,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [10:0]       H_CNT,
  input  logic [9:0]        V_CNT,
  input  logic              DE_IN,
  input  logic              HS_IN,
  input  logic              VS_IN,
  input  logic              EN_MOVE,
  input  logic [15:0]       ROM_Q,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [15:0]       DATA_OUT,
  output logic              DE_OUT,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic [10:0]       POS_X,
  output logic [9:0]        POS_Y
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  // 12-bit unsigned arithmetic, so that window bounds never wrap.
  localparam logic [11:0] MAX_X  = 12'(H_ACT - IMG_W);
  localparam logic [11:0] MAX_Y  = 12'(V_ACT - IMG_H);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [11:0] IMG_W12 = 12'(IMG_W);
  localparam logic [11:0] IMG_H12 = 12'(IMG_H);
  localparam logic [10:0] RST_X  = 11'((H_ACT - IMG_W) / 2);
  localparam logic [9:0]  RST_Y  = 10'((V_ACT - IMG_H) / 2);

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       data_out_q, data_out_d;
  logic [ROM_LAT:0]  win_pipe_q;             // in_win, stage 0 aligned with ROM_ADDR
  logic [ROM_LAT+1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [10:0]       pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  dir_e              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic              vs_prev_q;

  // ---------------------------------------------------------------------------
  // Stage 1: window test and ROM address
  // ---------------------------------------------------------------------------
  logic [11:0]   h12, v12, px12, py12;
  logic          in_win;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;

  assign h12  = {1'b0, H_CNT};
  assign v12  = {2'b00, V_CNT};
  assign px12 = {1'b0, pos_x_q};
  assign py12 = {2'b00, pos_y_q};

  assign in_win = DE_IN
                  && (h12 >= px12) && (h12 < px12 + IMG_W12)
                  && (v12 >= py12) && (v12 < py12 + IMG_H12);

  // Only the low bits of the offset are needed, because the window is a
  // power of 2 in each dimension.
  assign dx = XW'(H_CNT - pos_x_q);
  assign dy = YW'(V_CNT - pos_y_q);

  // Outside the window the address holds, so the ROM sees no spurious access.
  assign rom_addr_d = in_win ? ADDR_W'({dy, dx}) : rom_addr_q;

  // ---------------------------------------------------------------------------
  // Output mux: ROM data, background, or blank
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    data_out_d = 16'h0000;
    if (win_pipe_q[ROM_LAT])      data_out_d = ROM_Q;
    else if (de_pipe_q[ROM_LAT])  data_out_d = BG_COLOR;
  end

  // ---------------------------------------------------------------------------
  // Bounce logic; it acts only on the VS rising edge, which falls in blanking.
  // ---------------------------------------------------------------------------
  logic        vs_rise;
  logic [11:0] nx, ny;

  assign vs_rise = VS_IN & ~vs_prev_q;
  assign nx      = px12 + STEP12;
  assign ny      = py12 + STEP12;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (vs_rise && EN_MOVE) begin
      if (dir_x_q == DIR_POS) begin
        if (nx >= MAX_X) begin
          pos_x_d = 11'(MAX_X);
          dir_x_d = DIR_NEG;
        end else begin
          pos_x_d = 11'(nx);
        end
      end else if (px12 <= STEP12) begin
        pos_x_d = '0;
        dir_x_d = DIR_POS;
      end else begin
        pos_x_d = pos_x_q - 11'(STEP);
      end

      if (dir_y_q == DIR_POS) begin
        if (ny >= MAX_Y) begin
          pos_y_d = 10'(MAX_Y);
          dir_y_d = DIR_NEG;
        end else begin
          pos_y_d = 10'(ny);
        end
      end else if (py12 <= STEP12) begin
        pos_y_d = '0;
        dir_y_d = DIR_POS;
      end else begin
        pos_y_d = pos_y_q - 10'(STEP);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the delay lines are cleared on reset too, so outputs read 0 until real data refills them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q <= '0;
      data_out_q <= '0;
      win_pipe_q <= '0;
      de_pipe_q  <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      pos_x_q    <= RST_X;
      pos_y_q    <= RST_Y;
      dir_x_q    <= DIR_POS;
      dir_y_q    <= DIR_POS;
      vs_prev_q  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
      rom_addr_q <= rom_addr_d;
      data_out_q <= data_out_d;
      win_pipe_q <= {win_pipe_q[ROM_LAT-1:0], in_win};
      de_pipe_q  <= {de_pipe_q[ROM_LAT:0], DE_IN};
      hs_pipe_q  <= {hs_pipe_q[ROM_LAT:0], HS_IN};
      vs_pipe_q  <= {vs_pipe_q[ROM_LAT:0], VS_IN};
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      vs_prev_q  <= VS_IN;
    end
  end

  assign ROM_ADDR = rom_addr_q;
  assign DATA_OUT = data_out_q;
  assign DE_OUT   = de_pipe_q[ROM_LAT+1];
  assign HSYNC    = hs_pipe_q[ROM_LAT+1];
  assign VSYNC    = vs_pipe_q[ROM_LAT+1];
  assign POS_X    = pos_x_q;
  assign POS_Y    = pos_y_q;

endmodule

// File: tb/tb_vga_sprite_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_sprite_fetch
//
// Directed bench for vga_sprite_fetch. It uses STEP=4 and a distinctive
// background colour. The ROM model returns ~addr with 2 cycles of latency.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vga_sprite_fetch;

  localparam logic [15:0] BG = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        de_in, hs_in, vs_in, en_move;
  logic [15:0] rom_q;
  logic [15:0] rom_addr;
  logic [15:0] data_out;
  logic        de_out, hsync, vsync;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;

  int checks = 0;
  int errors = 0;

  vga_sprite_fetch #(
    .STEP     (4),
    .BG_COLOR (BG)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .H_CNT    (h_cnt),
    .V_CNT    (v_cnt),
    .DE_IN    (de_in),
    .HS_IN    (hs_in),
    .VS_IN    (vs_in),
    .EN_MOVE  (en_move),
    .ROM_Q    (rom_q),
    .ROM_ADDR (rom_addr),
    .DATA_OUT (data_out),
    .DE_OUT   (de_out),
    .HSYNC    (hsync),
    .VSYNC    (vsync),
    .POS_X    (pos_x),
    .POS_Y    (pos_y)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, 2-cycle latency, contents = ~address
  logic [15:0] rom_d1;
  always @(posedge clk) begin
    rom_d1 <= ~rom_addr;
    rom_q  <= rom_d1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one pixel for a single cycle, then idle. Check the address
  // 1 cycle later and the data/DE 4 cycles later.
  task automatic pix(input string tag, input logic [10:0] h, input logic [9:0] v,
                     input logic de, input logic [15:0] exp_addr,
                     input logic [15:0] exp_data, input logic exp_de);
    h_cnt = h; v_cnt = v; de_in = de;
    @(negedge clk);
    check({tag, "/addr"}, rom_addr, exp_addr);
    h_cnt = '0; v_cnt = '0; de_in = 1'b0;
    tick(3);
    check({tag, "/data"}, data_out, exp_data);
    check({tag, "/de"}, de_out, exp_de);
  endtask

  // One-cycle sync pulse; the output must be high exactly 4 cycles later.
  task automatic sync_pulse(input string tag, input logic is_vs);
    if (is_vs) vs_in = 1'b1; else hs_in = 1'b1;
    @(negedge clk);
    hs_in = 1'b0; vs_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("%s/t+%0d", tag, k), is_vs ? vsync : hsync, (k == 4));
    end
  endtask

  task automatic frame();
    vs_in = 1'b1;
    @(negedge clk);
    vs_in = 1'b0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; h_cnt = '0; v_cnt = '0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; en_move = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held: busy inputs, including VS edges with EN_MOVE=1, change nothing.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      h_cnt = 11'(300 + i); v_cnt = 10'd200; de_in = 1'b1;
      hs_in = i[0]; vs_in = ~i[0];
    end
    @(negedge clk);
    check("rst/rom_addr", rom_addr, 16'h0000);
    check("rst/data_out", data_out, 16'h0000);
    check("rst/de_out",   de_out,   1'b0);
    check("rst/hsync",    hsync,    1'b0);
    check("rst/vsync",    vsync,    1'b0);
    check("rst/pos_x",    pos_x,    11'd272);
    check("rst/pos_y",    pos_y,    10'd172);

    h_cnt = '0; v_cnt = '0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    en_move = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);

    // Window at (272,172), 256x256
    pix("px_tl",    11'd272, 10'd172, 1'b1, 16'h0000, 16'hFFFF, 1'b1);
    pix("px_br",    11'd527, 10'd427, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    pix("px_right", 11'd528, 10'd427, 1'b1, 16'hFFFF, BG,       1'b1);
    pix("px_mid",   11'd400, 10'd300, 1'b1, 16'h8080, 16'h7F7F, 1'b1);
    pix("px_left",  11'd271, 10'd300, 1'b1, 16'h8080, BG,       1'b1);
    pix("px_above", 11'd300, 10'd171, 1'b1, 16'h8080, BG,       1'b1);
    pix("px_below", 11'd300, 10'd428, 1'b1, 16'h8080, BG,       1'b1);
    pix("px_de0",   11'd300, 10'd200, 1'b0, 16'h8080, 16'h0000, 1'b0);
    pix("px_11",    11'd273, 10'd173, 1'b1, 16'h0101, 16'hFEFE, 1'b1);

    // Sync delay; the VS edge with EN_MOVE=0 must not move the window.
    sync_pulse("hs", 1'b0);
    sync_pulse("vs", 1'b1);
    check("hold/pos_x", pos_x, 11'd272);
    check("hold/pos_y", pos_y, 10'd172);

    // Bounce with STEP=4: X clamps at 544 on edge 68, Y clamps at 344 on edge 43.
    en_move = 1'b1;
    for (int f = 1; f <= 70; f++) begin
      frame();
      if (f == 1)  begin check("mv1/x", pos_x, 11'd276); check("mv1/y", pos_y, 10'd176); end
      if (f == 43) check("mv43/y", pos_y, 10'd344);
      if (f == 44) check("mv44/y", pos_y, 10'd340);
      if (f == 68) check("mv68/x", pos_x, 11'd544);
      if (f == 69) check("mv69/x", pos_x, 11'd540);
      if (f == 70) begin check("mv70/x", pos_x, 11'd536); check("mv70/y", pos_y, 10'd236); end
    end

    // EN_MOVE set and then cleared mid-frame: the next VS edge must hold position.
    en_move = 1'b1;
    tick(2);
    en_move = 1'b0;
    frame();
    check("stop/x", pos_x, 11'd536);
    check("stop/y", pos_y, 10'd236);

    // Stream a line through the window at (536,236), then reset mid-line.
    for (int i = 0; i < 6; i++) begin
      h_cnt = 11'(536 + i); v_cnt = 10'd236; de_in = 1'b1;
      @(negedge clk);
    end
    check("pre/de_out",   de_out,   1'b1);
    check("pre/data_out", data_out, 16'hFFFD);
    #2 rst_n = 1'b0;
    #1;
    check("mid/data_out", data_out, 16'h0000);
    check("mid/de_out",   de_out,   1'b0);
    check("mid/rom_addr", rom_addr, 16'h0000);
    check("mid/pos_x",    pos_x,    11'd272);
    check("mid/pos_y",    pos_y,    10'd172);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      h_cnt = 11'(272 + i); v_cnt = 10'd172; de_in = 1'b1;
      @(negedge clk);
      if (i == 2) check("rel/de_t3", de_out, 1'b0);
      if (i == 3) begin
        check("rel/data_t4", data_out, 16'hFFFF);
        check("rel/de_t4",   de_out,   1'b1);
      end
      if (i == 4) check("rel/data_t5", data_out, 16'hFFFE);
    end
    de_in = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
